// File: rtl/axis_pkg.sv
// Shared definitions for the sample-pair packer: FSM states, pad value and the
// helper that forms a packed word from two 16-bit samples.
package axis_pkg;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } pack_state_t;

    localparam logic [15:0] PAD_SAMPLE = 16'h0000;
    localparam logic [1:0]  PAD_STRB   = 2'b00;

    // First sample always occupies the upper half of the word.
    function automatic logic [31:0] pack_pair(input logic [15:0] hi, input logic [15:0] lo);
        return {hi, lo};
    endfunction

    function automatic logic [3:0] pack_strb(input logic [1:0] hi, input logic [1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// AXI-Stream master output register: holds a loaded word until the downstream
// handshake, and allows a new word to be loaded in the handshake cycle.
module axis_out_reg #(
    parameter int DATA_W = 32,
    parameter int STRB_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [STRB_W-1:0] i_strb,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [STRB_W-1:0] o_strb,
    output logic              o_last
);

    // Load has priority; the caller only loads when the register is free or draining.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_strb  <= '0;
            o_last  <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            o_strb  <= i_strb;
            o_last  <= i_last;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= o_valid;
        end
    end

endmodule

// File: rtl/sample_pair_pack.sv
// Packs consecutive 16-bit AXI-Stream samples into 32-bit words, padding an
// odd packet tail with a zero lower half; counts packets and padded words.
module sample_pair_pack
    import axis_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 16,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    input  logic                                  s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    output logic                                  s00_axis_tready,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic [15:0]                           pkt_count,
    output logic [15:0]                           pad_count
);

    pack_state_t r_state;
    pack_state_t w_next_state;
    logic [15:0] r_held_data;
    logic [1:0]  r_held_strb;
    logic [15:0] r_pkt_count;
    logic [15:0] r_pad_count;

    logic        w_s_ready;
    logic        w_accept;
    logic        w_load;
    logic        w_pad;
    logic        w_hold;
    logic [31:0] w_word;
    logic [3:0]  w_word_strb;
    logic        w_word_last;
    logic        w_m_valid;
    logic        w_m_last;

    assign w_s_ready       = s00_axis_aresetn && (!w_m_valid || m00_axis_tready);
    assign w_accept        = s00_axis_tvalid && w_s_ready;
    assign s00_axis_tready = w_s_ready;
    assign m00_axis_tvalid = w_m_valid;
    assign m00_axis_tlast  = w_m_last;
    assign pkt_count       = r_pkt_count;
    assign pad_count       = r_pad_count;

    // Next-state and output-word formation for each accepted beat.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_pad        = 1'b0;
        w_hold       = 1'b0;
        w_word       = 32'h0000_0000;
        w_word_strb  = 4'b0000;
        w_word_last  = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_EMPTY: begin
                    if (s00_axis_tlast) begin
                        w_load       = 1'b1;
                        w_pad        = 1'b1;
                        w_word       = pack_pair(s00_axis_tdata, PAD_SAMPLE);
                        w_word_strb  = pack_strb(s00_axis_tstrb, PAD_STRB);
                        w_word_last  = 1'b1;
                        w_next_state = ST_EMPTY;
                    end else begin
                        w_hold       = 1'b1;
                        w_next_state = ST_HALF;
                    end
                end
                ST_HALF: begin
                    w_load       = 1'b1;
                    w_word       = pack_pair(r_held_data, s00_axis_tdata);
                    w_word_strb  = pack_strb(r_held_strb, s00_axis_tstrb);
                    w_word_last  = s00_axis_tlast;
                    w_next_state = ST_EMPTY;
                end
                default: begin
                    w_next_state = ST_EMPTY;
                end
            endcase
        end else begin
            w_next_state = r_state;
        end
    end

    // FSM state and held upper-half sample.
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            r_state     <= ST_EMPTY;
            r_held_data <= 16'h0000;
            r_held_strb <= 2'b00;
        end else begin
            r_state <= w_next_state;
            if (w_hold) begin
                r_held_data <= s00_axis_tdata;
                r_held_strb <= s00_axis_tstrb;
            end
        end
    end

    // Packet and pad counters, both wrap naturally at 16 bits.
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            r_pkt_count <= 16'h0000;
            r_pad_count <= 16'h0000;
        end else begin
            if (w_m_valid && m00_axis_tready && w_m_last) begin
                r_pkt_count <= r_pkt_count + 16'h0001;
            end
            if (w_pad) begin
                r_pad_count <= r_pad_count + 16'h0001;
            end
        end
    end

    axis_out_reg #(
        .DATA_W (C_M00_AXIS_TDATA_WIDTH),
        .STRB_W (C_M00_AXIS_TDATA_WIDTH/8)
    ) u_out_reg (
        .i_clk   (s00_axis_aclk),
        .i_rst_n (s00_axis_aresetn),
        .i_load  (w_load),
        .i_data  (w_word),
        .i_strb  (w_word_strb),
        .i_last  (w_word_last),
        .i_ready (m00_axis_tready),
        .o_valid (w_m_valid),
        .o_data  (m00_axis_tdata),
        .o_strb  (m00_axis_tstrb),
        .o_last  (w_m_last)
    );

endmodule

// File: tb/tb_sample_pair_pack.sv
// Self-checking bench for sample_pair_pack: directed cases plus a randomized
// packet stream scored against a packet-level model of the pairing rules.
module tb_sample_pair_pack;

    logic        clk;
    logic        rstn;
    logic        s_tvalid;
    logic        s_tlast;
    logic [15:0] s_tdata;
    logic [1:0]  s_tstrb;
    logic        s_tready;
    logic        m_tready;
    logic        m_tvalid;
    logic        m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic [15:0] pkt_count;
    logic [15:0] pad_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic        m_tready_dir = 1'b1;
    logic        rand_mode    = 1'b0;

    // Word record: {data[31:0], strb[3:0], last}
    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];
    logic [15:0] cur_d[$];
    logic [1:0]  cur_s[$];
    logic [15:0] pad_exp = 16'h0000;
    logic [15:0] pkt_exp = 16'h0000;

    sample_pair_pack dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rstn),
        .s00_axis_tvalid  (s_tvalid),
        .s00_axis_tlast   (s_tlast),
        .s00_axis_tdata   (s_tdata),
        .s00_axis_tstrb   (s_tstrb),
        .s00_axis_tready  (s_tready),
        .m00_axis_tready  (m_tready),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tstrb   (m_tstrb),
        .pkt_count        (pkt_count),
        .pad_count        (pad_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Downstream ready: directed value or random per cycle.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rand_mode) m_tready = 1'($urandom_range(0, 1));
            else           m_tready = m_tready_dir;
        end
    end

    // Monitor: handshakes observed mid-cycle, packet-level expected words.
    always @(negedge clk) begin
        if (!rstn) begin
            check_val("s_tready_in_reset", {63'd0, s_tready}, 64'd0);
            cur_d.delete();
            cur_s.delete();
            got_q.delete();
            exp_q.delete();
            pad_exp = 16'h0000;
            pkt_exp = 16'h0000;
        end else begin
            check_val("s_tready_rule", {63'd0, s_tready}, {63'd0, (!m_tvalid || m_tready)});
            if (m_tvalid && m_tready) got_q.push_back({m_tdata, m_tstrb, m_tlast});
            if (s_tvalid && s_tready) begin
                cur_d.push_back(s_tdata);
                cur_s.push_back(s_tstrb);
                if (s_tlast) begin
                    pkt_exp = pkt_exp + 16'h0001;
                    for (int i = 0; i < cur_d.size(); i += 2) begin
                        if (i + 1 < cur_d.size()) begin
                            exp_q.push_back({cur_d[i], cur_d[i+1], cur_s[i], cur_s[i+1],
                                             (i + 2 == cur_d.size())});
                        end else begin
                            exp_q.push_back({cur_d[i], 16'h0000, cur_s[i], 2'b00, 1'b1});
                            pad_exp = pad_exp + 16'h0001;
                        end
                    end
                    cur_d.delete();
                    cur_s.delete();
                end
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic [1:0] st, input logic last);
        bit ok;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tstrb  = st;
        s_tlast  = last;
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (s_tready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!m_tvalid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic compare_streams(input string tag);
        logic [36:0] g;
        logic [36:0] e;
        check_val({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check_val({tag, "_word"}, {27'd0, g}, {27'd0, e});
        end
        got_q.delete();
        exp_q.delete();
        check_val({tag, "_pkt_count"}, {48'd0, pkt_count}, {48'd0, pkt_exp});
        check_val({tag, "_pad_count"}, {48'd0, pad_count}, {48'd0, pad_exp});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        int total;
        int len;
        rstn     = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 16'h0000;
        s_tstrb  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        check_val("rst_m_tdata", {32'd0, m_tdata}, 64'd0);
        check_val("rst_m_tstrb", {60'd0, m_tstrb}, 64'd0);
        check_val("rst_m_tlast", {63'd0, m_tlast}, 64'd0);
        check_val("rst_pkt_count", {48'd0, pkt_count}, 64'd0);
        check_val("rst_pad_count", {48'd0, pad_count}, 64'd0);
        rstn = 1'b1;

        // Basic even packet with latency checks
        m_tready_dir = 1'b1;
        send(16'h0001, 2'b11, 1'b0);
        check_val("no_out_after_first", {63'd0, m_tvalid}, 64'd0);
        send(16'h0002, 2'b11, 1'b0);
        check_val("latency_valid", {63'd0, m_tvalid}, 64'd1);
        check_val("latency_data", {32'd0, m_tdata}, 64'h0001_0002);
        send(16'h0003, 2'b11, 1'b0);
        send(16'h0004, 2'b11, 1'b1);
        check_val("w2_data", {32'd0, m_tdata}, 64'h0003_0004);
        check_val("w2_strb", {60'd0, m_tstrb}, 64'hF);
        check_val("w2_last", {63'd0, m_tlast}, 64'd1);
        drain();
        compare_streams("even_pkt");
        check_val("even_pkt_count1", {48'd0, pkt_count}, 64'd1);

        // Odd packet with padded tail and signed extremes
        do_reset();
        send(16'h7FFF, 2'b11, 1'b0);
        send(16'h8000, 2'b11, 1'b0);
        send(16'h1234, 2'b11, 1'b1);
        check_val("pad_data", {32'd0, m_tdata}, 64'h1234_0000);
        check_val("pad_strb", {60'd0, m_tstrb}, 64'hC);
        check_val("pad_last", {63'd0, m_tlast}, 64'd1);
        drain();
        check_val("pad_count1", {48'd0, pad_count}, 64'd1);
        compare_streams("odd_pkt");

        // Downstream stall holds the word and blocks the slave side
        do_reset();
        m_tready_dir = 1'b0;
        @(posedge clk);
        #1;
        send(16'h1111, 2'b01, 1'b0);
        send(16'h2222, 2'b10, 1'b1);
        s_tvalid = 1'b1;
        s_tdata  = 16'h3333;
        s_tstrb  = 2'b11;
        s_tlast  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_val("stall_data", {32'd0, m_tdata}, 64'h1111_2222);
            check_val("stall_valid", {63'd0, m_tvalid}, 64'd1);
            check_val("stall_s_tready", {63'd0, s_tready}, 64'd0);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        m_tready_dir = 1'b1;
        drain();
        compare_streams("stall");

        // Reset while holding a half word discards it
        do_reset();
        send(16'hAAAA, 2'b11, 1'b0);
        do_reset();
        check_val("midrst_valid", {63'd0, m_tvalid}, 64'd0);
        send(16'h0005, 2'b11, 1'b0);
        send(16'h0006, 2'b11, 1'b1);
        check_val("midrst_data", {32'd0, m_tdata}, 64'h0005_0006);
        drain();
        compare_streams("midrst");

        // Randomized packet stream with random valid/ready
        do_reset();
        rand_mode = 1'b1;
        total = 0;
        while (total < 2048) begin
            len = $urandom_range(1, 9);
            if (total + len > 2048) len = 2048 - total;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send(16'($urandom), 2'($urandom), (i == len - 1));
            end
            total += len;
        end
        rand_mode = 1'b0;
        drain();
        compare_streams("random");

        // Single-sample packets until both counters wrap
        do_reset();
        m_tready_dir = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 65536; i++) begin
            send(16'(i), 2'b11, 1'b1);
        end
        drain();
        check_val("wrap_pad_zero", {48'd0, pad_count}, 64'd0);
        check_val("wrap_pkt_zero", {48'd0, pkt_count}, 64'd0);
        compare_streams("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sample_pair_pack.md
SAMPLE_PAIR_PACK -- requirements
Module: sample_pair_pack

Interface
REQ-001 SHALL have parameter C_S00_AXIS_TDATA_WIDTH, default 16, slave sample width (fixed at 16; other values are unsupported).
REQ-002 SHALL have parameter C_M00_AXIS_TDATA_WIDTH, default 32, master word width (fixed at 32).
REQ-003 SHALL use one clock; reset is synchronous and active-low: s00_axis_aclk  in  1  sole clock for both sides.
REQ-004 s00_axis_aresetn  in  1  synchronous active-low reset, both sides.
REQ-005 s00_axis_tvalid, s00_axis_tlast  in  1 each  slave valid, end-of-packet.
REQ-006 s00_axis_tdata  in  16  signed sample.
REQ-007 s00_axis_tstrb  in  2  byte strobes of the sample.
REQ-008 s00_axis_tready  out  1  slave ready.
REQ-009 m00_axis_tready  in  1  master ready.
REQ-010 m00_axis_tvalid, m00_axis_tlast  out  1 each  master valid, end-of-packet.
REQ-011 m00_axis_tdata  out  32  packed pair: first sample in [31:16], second in [15:0].
REQ-012 m00_axis_tstrb  out  4  {first-sample strb, second-sample strb}.
REQ-013 pkt_count  out  16  number of master packets completed (tlast beats accepted downstream).
REQ-014 pad_count  out  16  number of padded (odd-tail) words emitted.

Function
REQ-015 SHALL pack consecutive accepted 16-bit samples into 32-bit words, producing the format consumed by the pair-split/square-sum stage.
REQ-016 SHALL implement a two-state FSM: EMPTY (no held sample), HALF (first sample held in upper register).
REQ-017 EMPTY, accepted beat with tlast=0 -> store sample and strb as upper half, go to HALF; no output.
REQ-018 EMPTY, accepted beat with tlast=1 -> load output word {sample, 16'h0000}, tstrb {strb, 2'b00}, tlast=1, increment pad_count; remain in EMPTY.
REQ-019 HALF, accepted beat -> load output word {held, sample}, tstrb {held strb, strb}, tlast=input tlast; go to EMPTY.
REQ-020 s00_axis_tready SHALL equal (!m00_axis_tvalid || m00_axis_tready) in both states, combinationally.
REQ-021 A beat is accepted only when s00_axis_tvalid && s00_axis_tready on a rising edge.
REQ-022 Output register SHALL hold tdata/tstrb/tlast stable while m00_axis_tvalid=1 and m00_axis_tready=0.
REQ-023 m00_axis_tvalid SHALL deassert after a downstream handshake unless a new word is loaded in the same cycle (back-to-back allowed).
REQ-024 Latency: accepted second sample (or padded tail) -> m00_axis_tvalid high on the next cycle (1 cycle).
REQ-025 Sustained throughput with tready=1: one input per cycle, one output word every 2 cycles.
REQ-026 pkt_count SHALL increment by 1 on each master handshake with m00_axis_tlast=1; pad_count on each padded word loaded; both wrap 16'hFFFF -> 0.
REQ-027 Input tvalid low SHALL not change FSM state or held sample.

Reset
REQ-028 On s00_axis_aresetn=0 at a clock edge: FSM -> EMPTY, held sample/strb -> 0, m00_axis_tvalid/tlast/tdata/tstrb -> 0, pkt_count/pad_count -> 0.
REQ-029 Reset mid-packet (HALF) SHALL discard the held sample; no partial word is ever emitted.
REQ-030 s00_axis_tready SHALL be 0 while reset is asserted.

Structure
REQ-031 FSM state enum and pad value (16'h0000) SHALL live in the shared package axis_pkg.
REQ-032 Output register with valid/hold logic SHALL be a sub-module axis_out_reg (32-bit data, 4-bit strb, last); FSM and counters in the top.

Verification
REQ-033 Samples 0x0001,0x0002,0x0003,0x0004(tlast), tready=1 -> words 0x00010002 (tlast=0), 0x00030004 (tlast=1), tstrb 4'hF, pkt_count=1.
REQ-034 Samples 0x7FFF,0x8000,0x1234(tlast) -> 0x7FFF8000, then 0x12340000 tstrb 4'b1100 tlast=1; pad_count=1.
REQ-035 Two samples sent, m00_axis_tready held low 5 cycles -> tdata stable, s00_axis_tready=0 throughout, word delivered exactly once on release.
REQ-036 Reset asserted one cycle after first sample 0xAAAA (HALF) -> after release, samples 0x0005,0x0006(tlast) yield only 0x00050006.
REQ-037 Continuous 2048-sample stream, random tvalid/tready -> scoreboard exact match, no loss/duplication, pkt_count matches tlast count.
REQ-038 65536 single-sample packets -> pad_count and pkt_count wrap to 0.
